mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage access controller. It reads the EX/MEM pipeline register outputs and drives a multi-cycle (stalling) data memory.
- While an access is outstanding it freezes the upstream pipeline. It delivers read data to the MEM/WB register in the cycle the access completes.
- It detects misaligned and timed-out accesses and converts them into a sticky error plus a halt request.

Parameters:
- TIMEOUT_CYCLES, 15: maximum WAIT cycles without mem_done before an error is declared (legal range 1..255).
- ALIGN_CHECK, 1: when 1, a word access with addr[0]=1 is an error; when 0, addr[0] is ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- exm_valid  in  1  EX/MEM slot holds a live instruction
- exm_mem_read  in  1  instruction is a load
- exm_mem_write  in  1  instruction is a store
- exm_addr  in  16  ALU result used as the data address
- exm_wdata  in  16  store data (register read data 2)
- exm_halt  in  1  instruction is HALT
- mem_req  out  1  request strobe to data memory
- mem_wr  out  1  1 = write, 0 = read (qualified by mem_req)
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data (valid with mem_done)
- mem_done  in  1  access complete
- stall_pipe  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert bubble into MEM/WB
- wb_valid  out  1  access completes this cycle
- wb_rdata  out  16  load data to MEM/WB
- err  out  1  sticky error
- halt_out  out  1  halt request to the WB/halt logic

Behaviour:
- Reset (asynchronous, active-high) forces: state=IDLE, wait counter=0, addr_q=0, wdata_q=0, wr_q=0, err=0. All outputs are 0 during and after reset until the next stimulus.
- An access is exm_valid & (exm_mem_read | exm_mem_write). If both read and write are set, the access is treated as a write.
- IDLE state:
  - Access present and aligned: mem_req=1 and mem_wr=exm_mem_write, with mem_addr/mem_wdata taken directly from exm_addr/exm_wdata. addr_q, wdata_q and wr_q are captured.
  - If mem_done=1 in the same cycle (hit): stall_pipe=0, wb_valid=1, and the controller stays in IDLE.
  - Otherwise: stall_pipe=1 and the next state is WAIT.
  - Misaligned access (ALIGN_CHECK=1 and exm_addr[0]=1): mem_req=0, err is set, and the next state is ERR.
  - No access: all memory outputs are 0. halt_out=exm_valid&exm_halt.
  - mem_done while idle with no request is ignored.
- WAIT state:
  - mem_req=0; mem_addr/mem_wdata/mem_wr are held from the _q registers.
  - stall_pipe=1 until mem_done is seen. The counter increments every cycle in which mem_done=0.
  - mem_done=1: stall_pipe=0 and wb_valid=1 that cycle, counter cleared, next state IDLE. Zero-cycle turnaround: a new access can be issued in the following IDLE cycle.
  - counter==TIMEOUT_CYCLES with mem_done=0: err is set, stall_pipe=0, next state ERR. If mem_done and the timeout coincide, mem_done wins.
- ERR state: absorbing until reset. mem_req=0, stall_pipe=0, err=1, halt_out=1.
- wb_rdata:
  - Equals mem_rdata when wb_valid & read; otherwise 0.
  - Writes always present wb_rdata=0.
- Latency:
  - Hit: 0 extra cycles.
  - Miss with done N cycles after the request: stall_pipe is high for exactly N cycles, counting the request cycle as cycle 0.
- Reset during WAIT returns to IDLE immediately. mem_req drops asynchronously; the memory shares rst.
- Counter width is clog2(TIMEOUT_CYCLES+1). The counter never wraps because the controller leaves WAIT at TIMEOUT_CYCLES.

Decomposition:
- Shared constants header: state encodings IDLE=2'b00, WAIT=2'b01, ERR=2'b10. 2'b11 is illegal and decodes to ERR.
- One sub-module, wait_timer: a counter with clear/enable and a terminal-count flag, parameterised by TIMEOUT_CYCLES.
- Flops use the team's async-reset dff variant.

Test Plan:
- Load hit: exm_valid=1, read=1, addr=0x0010, mem_done=1 with rdata=0xBEEF in the same cycle → mem_req=1, stall_pipe=0, wb_valid=1, wb_rdata=0xBEEF, state stays IDLE.
- Store miss: write=1, addr=0x0022, wdata=0x1234, mem_done asserted 3 cycles later → mem_req is high for 1 cycle with mem_wr=1. stall_pipe is high for 3 cycles with mem_addr/mem_wdata stable. wb_valid=1 and wb_rdata=0 on the done cycle.
- Misaligned: read with addr=0x0013 → mem_req never asserts. err=1 and halt_out=1 from the next cycle, and both persist.
- Timeout: TIMEOUT_CYCLES=4, read issued, mem_done never arrives → err rises after the 4th WAIT cycle, and stall_pipe drops in that cycle. A second run with done arriving exactly on the 4th WAIT cycle must complete normally with err=0.
- Reset mid-WAIT: assert rst 2 cycles into WAIT → mem_req, stall_pipe and err go to 0 immediately. After rst deasserts, a fresh hit load completes normally.
- Halt: exm_valid=1, halt=1, no access → halt_out=1 that cycle, mem_req=0, stall_pipe=0.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared widths, state encoding and request record for the memory-stage access controller.
package mem_access_ctrl_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  // 2'b11 is not listed; the controller decodes it as ST_ERR.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic is_misaligned(input logic addr_lsb, input bit check_en);
    return check_en & addr_lsb;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Wait-state timer: clear/enable counter with a terminal-count flag at TIMEOUT_CYCLES.
// Registered count, combinational flag; enable is ignored at terminal count so the count never wraps.
module wait_timer
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned      CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues EX/MEM loads/stores to a stalling data memory.
// Hits complete in the request cycle; misses hold stall_pipe until mem_done; misalign/timeout go to a sticky error.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter bit          ALIGN_CHECK    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exm_valid,
  input  logic              exm_mem_read,
  input  logic              exm_mem_write,
  input  logic [ADDR_W-1:0] exm_addr,
  input  logic [DATA_W-1:0] exm_wdata,
  input  logic              exm_halt,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              stall_pipe,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              err,
  output logic              halt_out
);

  state_e state_q, state_d;
  req_t   req_q, req_d;
  logic   err_q, err_d;

  logic tmr_clr, tmr_en, tmr_tc;

  logic access;
  logic misaligned;

  logic              mem_req_c, mem_wr_c, stall_c, wb_valid_c, halt_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c, wb_rdata_c;

  assign access     = exm_valid & (exm_mem_read | exm_mem_write);
  assign misaligned = is_misaligned(exm_addr[0], ALIGN_CHECK);

  // The timer also counts the missed request cycle, so in WAIT cycle k it holds k.
  wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .tc_o (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    err_d       = err_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    mem_req_c   = 1'b0;
    mem_wr_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    stall_c     = 1'b0;
    wb_valid_c  = 1'b0;
    wb_rdata_c  = '0;
    halt_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        halt_c = exm_valid & exm_halt;
        if (access) begin
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            mem_req_c   = 1'b1;
            mem_wr_c    = exm_mem_write;
            mem_addr_c  = exm_addr;
            mem_wdata_c = exm_wdata;
            req_d       = '{wr: exm_mem_write, addr: exm_addr, wdata: exm_wdata};
            if (mem_done) begin
              wb_valid_c = 1'b1;
              wb_rdata_c = exm_mem_write ? '0 : mem_rdata;
              tmr_clr    = 1'b1;
            end else begin
              stall_c = 1'b1;
              tmr_en  = 1'b1;
              state_d = ST_WAIT;
            end
          end
        end
      end

      ST_WAIT: begin
        mem_wr_c    = req_q.wr;
        mem_addr_c  = req_q.addr;
        mem_wdata_c = req_q.wdata;
        // A completion in the timeout cycle still counts as a completion.
        if (mem_done) begin
          wb_valid_c = 1'b1;
          wb_rdata_c = req_q.wr ? '0 : mem_rdata;
          tmr_clr    = 1'b1;
          state_d    = ST_IDLE;
        end else if (tmr_tc) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          stall_c = 1'b1;
          tmr_en  = 1'b1;
        end
      end

      default: begin
        halt_c  = 1'b1;
        err_d   = 1'b1;
        state_d = ST_ERR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced low while rst is high, so a live EX/MEM slot cannot strobe memory during reset.
  assign mem_req    = mem_req_c & ~rst;
  assign mem_wr     = mem_wr_c & ~rst;
  assign mem_addr   = rst ? '0 : mem_addr_c;
  assign mem_wdata  = rst ? '0 : mem_wdata_c;
  assign stall_pipe = stall_c & ~rst;
  assign wb_valid   = wb_valid_c & ~rst;
  assign wb_rdata   = rst ? '0 : wb_rdata_c;
  assign halt_out   = halt_c & ~rst;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: randomized loads/stores against a latency/result model, scoreboarded
// on wb_valid, plus directed hit, miss, misalign, timeout, reset-in-WAIT and halt scenarios.
module tb_mem_access_ctrl;

  localparam int unsigned T = 4;

  logic        clk;
  logic        rst;
  logic        exm_valid, exm_mem_read, exm_mem_write, exm_halt;
  logic [15:0] exm_addr, exm_wdata, mem_rdata;
  logic        mem_done;
  logic        mem_req, mem_wr, stall_pipe, wb_valid, err, halt_out;
  logic [15:0] mem_addr, mem_wdata, wb_rdata;

  mem_access_ctrl #(
    .TIMEOUT_CYCLES(T),
    .ALIGN_CHECK   (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .exm_valid    (exm_valid),
    .exm_mem_read (exm_mem_read),
    .exm_mem_write(exm_mem_write),
    .exm_addr     (exm_addr),
    .exm_wdata    (exm_wdata),
    .exm_halt     (exm_halt),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .stall_pipe   (stall_pipe),
    .wb_valid     (wb_valid),
    .wb_rdata     (wb_rdata),
    .err          (err),
    .halt_out     (halt_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic [15:0] rdata;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stall_seen = 0;
  int   req_seen   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the model's expectation whenever the DUT retires an access.
  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 0;
      req_seen   = 0;
    end else begin
      if (stall_pipe) stall_seen++;
      if (mem_req) req_seen++;
      if ((stall_pipe || mem_req) && exp_q.size() != 0) begin
        check("mem_addr", mem_addr, exp_q[0].addr);
        check("mem_wdata", mem_wdata, exp_q[0].wdata);
        check("mem_wr", mem_wr, exp_q[0].wr);
      end
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: wb_valid=1 with no outstanding access at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("wb_rdata", wb_rdata, mon_e.rdata);
          check("stall_cycles", stall_seen, mon_e.stalls);
          check("req_pulses", req_seen, 1);
        end
        stall_seen = 0;
        req_seen   = 0;
      end else begin
        check("wb_rdata_quiet", wb_rdata, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    exm_valid     = 1'b0;
    exm_mem_read  = 1'b0;
    exm_mem_write = 1'b0;
    exm_halt      = 1'b0;
    exm_addr      = 16'h0;
    exm_wdata     = 16'h0;
    mem_done      = 1'b0;
    mem_rdata     = 16'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  // Aligned access answered `delay` cycles after the request (delay <= T always completes).
  task automatic do_access(input bit rd, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rdata, input int delay);
    exp_t e;
    e.addr   = addr;
    e.wdata  = wdata;
    e.wr     = wr;
    e.rdata  = wr ? 16'h0 : rdata;
    e.stalls = delay;
    exp_q.push_back(e);
    exm_valid     = 1'b1;
    exm_mem_read  = rd;
    exm_mem_write = wr;
    exm_addr      = addr;
    exm_wdata     = wdata;
    exm_halt      = 1'b0;
    for (int k = 0; k <= delay; k++) begin
      mem_done  = (k == delay);
      mem_rdata = (k == delay) ? rdata : 16'($urandom);
      @(negedge clk);
      check("req_strobe", mem_req, (k == 0));
      check("stall_cycle", stall_pipe, (k < delay));
      check("wb_valid_cycle", wb_valid, (k == delay));
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_stall", stall_pipe, 0);
    check("rst_err", err, 0);
    exm_valid    = 1'b1;
    exm_mem_read = 1'b1;
    exm_addr     = 16'h0010;
    #1;
    check("rst_gates_req", mem_req, 0);
    check("rst_gates_addr", mem_addr, 0);
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_outputs", {mem_req, mem_wr, stall_pipe, wb_valid, err, halt_out}, 0);
    next_cycle();

    // Load hit and store miss
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0);
    do_access(1'b0, 1'b1, 16'h0022, 16'h1234, 16'h5A5A, 3);

    // Randomized traffic, including back-to-back and spurious idle mem_done
    for (int n = 0; n < 40; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 2);
      do_access(sel != 1, sel != 0, 16'($urandom) & 16'hFFFE, 16'($urandom), 16'($urandom),
                int'($urandom_range(0, T)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        exm_valid = 1'($urandom);
        exm_halt  = 1'($urandom);
        mem_done  = 1'($urandom);
        mem_rdata = 16'($urandom);
        @(negedge clk);
        check("idle_halt", halt_out, exm_valid & exm_halt);
        check("idle_req", mem_req, 0);
        check("idle_stall", stall_pipe, 0);
        next_cycle();
        idle_inputs();
      end
    end

    // Completion exactly on the last allowed WAIT cycle
    do_access(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h7E57, T);
    @(negedge clk);
    check("late_done_no_err", err, 0);
    next_cycle();

    // Timeout: memory never answers
    exm_valid    = 1'b1;
    exm_mem_read = 1'b1;
    exm_addr     = 16'h0040;
    for (int k = 0; k <= T; k++) begin
      @(negedge clk);
      check("to_stall", stall_pipe, (k < T));
      check("to_err_pending", err, 0);
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("to_err", err, 1);
      check("to_halt", halt_out, 1);
      check("to_req", mem_req, 0);
      check("to_stall_low", stall_pipe, 0);
      next_cycle();
    end
    do_reset();

    // Misaligned load
    exm_valid    = 1'b1;
    exm_mem_read = 1'b1;
    exm_addr     = 16'h0013;
    @(negedge clk);
    check("mis_req", mem_req, 0);
    check("mis_stall", stall_pipe, 0);
    next_cycle();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mis_err", err, 1);
      check("mis_halt", halt_out, 1);
      check("mis_req_after", mem_req, 0);
      next_cycle();
    end
    do_reset();

    // Reset two cycles into WAIT
    exm_valid    = 1'b1;
    exm_mem_read = 1'b1;
    exm_addr     = 16'h0050;
    next_cycle();
    next_cycle();
    #2;
    check("wait_stall_before_rst", stall_pipe, 1);
    rst = 1'b1;
    #1;
    check("rst_wait_req", mem_req, 0);
    check("rst_wait_stall", stall_pipe, 0);
    check("rst_wait_err", err, 0);
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    do_access(1'b1, 1'b0, 16'h0060, 16'h0000, 16'hCAFE, 0);

    // Halt with no memory access
    exm_valid = 1'b1;
    exm_halt  = 1'b1;
    @(negedge clk);
    check("halt_out", halt_out, 1);
    check("halt_req", mem_req, 0);
    check("halt_stall", stall_pipe, 0);
    next_cycle();
    idle_inputs();

    next_cycle();
    next_cycle();
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
